m_bcd_timer: RTL and testbench

M_BCD_TIMER -- requirements
Module: m_bcd_timer

---
 rtl/m_bcd_timer.sv | 133 +++++++++++++
 tb/tb_m_bcd_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/m_bcd_timer.sv
// Prescaled multi-digit BCD up/down timer with IDLE/RUN/PAUSE control,
// lap-freeze display register, one-hot decode of the low digit and wrap strobe.
module m_bcd_timer #(
  parameter int PRESCALE = 5000000,
  parameter int DIGITS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clr,
  input  logic                dir,
  input  logic                hold,
  output logic [4*DIGITS-1:0] digits,
  output logic [9:0]          onehot,
  output logic                tick,
  output logic                tc,
  output logic                running
);

  localparam int PW = $clog2(PRESCALE);
  localparam int CW = 4 * DIGITS;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_step;
  logic [CW-1:0]   disp_q, disp_d;
  logic            tc_q, tc_d;
  logic            running_q;
  logic            step;
  logic            wrap;

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (state_q == RUN && stop) begin
      state_d = PAUSE;
    end else if (start && state_q != RUN) begin
      state_d = RUN;
    end
  end

  always_comb begin
    pre_d = pre_q;
    if (clr || state_q == IDLE) begin
      pre_d = '0;
    end else if (state_q == RUN) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    end
  end

  assign tick = (state_q == RUN) && (pre_q == PRE_MAX);
  assign step = tick && !clr;

  // Ripple carry (up) or borrow (down) through the digits; a carry that
  // survives the top digit means the whole count wrapped.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    cnt_step = cnt_q;
    carry    = 1'b1;
    dig      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = cnt_q[4*i +: 4];
      if (carry) begin
        if (!dir) begin
          if (dig >= 4'd9) begin
            cnt_step[4*i +: 4] = 4'd0;
          end else begin
            cnt_step[4*i +: 4] = dig + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (dig == 4'd0 || dig > 4'd9) begin
            cnt_step[4*i +: 4] = 4'd9;
          end else begin
            cnt_step[4*i +: 4] = dig - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
    wrap = carry;
  end

  always_comb begin
    cnt_d  = clr ? '0 : (step ? cnt_step : cnt_q);
    tc_d   = step && wrap;
    disp_d = clr ? '0 : (hold ? disp_q : cnt_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      tc_q      <= tc_d;
      running_q <= (state_d == RUN);
    end
  end

  always_comb begin
    onehot = '0;
    for (int n = 0; n < 10; n++) begin
      onehot[n] = (disp_q[3:0] == 4'(n));
    end
  end

  assign digits  = disp_q;
  assign tc      = tc_q;
  assign running = running_q;

endmodule

// File: tb/tb_m_bcd_timer.sv
// Directed bench for m_bcd_timer (PRESCALE=4, DIGITS=2): a decimal-integer
// reference model queues the expected outputs of each cycle for comparison.
module tb_m_bcd_timer;

  localparam int P      = 4;
  localparam int D      = 2;
  localparam int MAXV   = 100;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PAUS = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, stop = 1'b0, clr = 1'b0, dir = 1'b0, hold = 1'b0;
  logic [4*D-1:0] digits;
  logic [9:0]   onehot;
  logic         tick, tc, running;

  m_bcd_timer #(.PRESCALE(P), .DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .dir(dir),
    .hold(hold), .digits(digits), .onehot(onehot), .tick(tick), .tc(tc),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*D-1:0] digits;
    logic [9:0]     onehot;
    logic           tick;
    logic           tc;
    logic           running;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_st, m_pre, m_cnt, m_disp;
  bit   m_tc;
  bit   last_tick;
  int   ticks_seen;

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic s, input logic sp, input logic c, input logic h, input logic r);
    exp_t e;
    int   nst, npre, ncnt, ndisp;
    bit   ntc, tk, stp;
    start = s; stop = sp; clr = c; hold = h; rst = r;
    tk = (m_st == S_RUN) && (m_pre == P - 1);
    e.digits  = to_bcd(m_disp);
    e.onehot  = 10'(1) << (m_disp % 10);
    e.tick    = tk;
    e.tc      = m_tc;
    e.running = (m_st == S_RUN);
    sb.push_back(e);
    if (r) begin
      nst = S_IDLE; npre = 0; ncnt = 0; ndisp = 0; ntc = 0;
    end else begin
      stp  = tk && !c;
      ncnt = c ? 0 : (stp ? (dir ? (m_cnt + MAXV - 1) % MAXV : (m_cnt + 1) % MAXV) : m_cnt);
      ntc  = stp && (dir ? (m_cnt == 0) : (m_cnt == MAXV - 1));
      if (c || m_st == S_IDLE) npre = 0;
      else if (m_st == S_RUN)  npre = (m_pre == P - 1) ? 0 : m_pre + 1;
      else                     npre = m_pre;
      if (c)                              nst = S_IDLE;
      else if (m_st == S_RUN && sp)       nst = S_PAUS;
      else if (s && m_st != S_RUN)        nst = S_RUN;
      else                                nst = m_st;
      ndisp = c ? 0 : (h ? m_disp : ncnt);
    end
    @(negedge clk);
    e = sb.pop_front();
    chk("digits",  32'(digits),  32'(e.digits));
    chk("onehot",  32'(onehot),  32'(e.onehot));
    chk("tick",    32'(tick),    32'(e.tick));
    chk("tc",      32'(tc),      32'(e.tc));
    chk("running", 32'(running), 32'(e.running));
    last_tick = tick;
    if (tick) ticks_seen++;
    @(posedge clk);
    #1;
    m_st = nst; m_pre = npre; m_cnt = ncnt; m_disp = ndisp; m_tc = ntc;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    m_st = S_IDLE; m_pre = 0; m_cnt = 0; m_disp = 0; m_tc = 0;
    cyc(0, 0, 0, 0, 1);
    chk("rst_digits", 32'(digits), 32'h00);
    chk("rst_onehot", 32'(onehot), 32'h001);

    // Basic up-count: 40 cycles of RUN give ten ticks and a display of 10.
    cyc(1, 0, 0, 0, 0);
    ticks_seen = 0;
    idle_cycles(40);
    chk("up40_ticks",  32'(ticks_seen), 32'd10);
    chk("up40_digits", 32'(digits), 32'h10);
    chk("up40_run",    32'(running), 32'd1);

    // Up-wrap 99 -> 00 then down-wrap 00 -> 99.
    for (n = 0; n < 1000 && m_disp != 99; n++) cyc(0, 0, 0, 0, 0);
    chk("reach_99", 32'(m_disp == 99), 32'd1);
    idle_cycles(4);
    chk("upwrap_digits", 32'(digits), 32'h00);
    chk("upwrap_tc",     32'(tc), 32'd1);
    idle_cycles(1);
    chk("upwrap_tc_off", 32'(tc), 32'd0);
    dir = 1'b1;
    idle_cycles(3);
    chk("dnwrap_digits", 32'(digits), 32'h99);
    chk("dnwrap_tc",     32'(tc), 32'd1);

    // Pause with prescaler held at 2; first tick two cycles after restart.
    for (n = 0; n < 10 && m_pre != 1; n++) cyc(0, 0, 0, 0, 0);
    chk("reach_pre1", 32'(m_pre), 32'd1);
    cyc(0, 1, 0, 0, 0);
    idle_cycles(10);
    chk("pause_digits", 32'(digits), 32'(to_bcd(m_disp)));
    chk("pause_run",    32'(running), 32'd0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("restart_tick1", 32'(last_tick), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("restart_tick2", 32'(last_tick), 32'd1);

    // Lap freeze at 05 while the count advances to 08.
    cyc(0, 0, 1, 0, 0);
    dir = 1'b0;
    cyc(1, 0, 0, 0, 0);
    for (n = 0; n < 100 && m_disp != 5; n++) cyc(0, 0, 0, 0, 0);
    chk("reach_05", 32'(digits), 32'h05);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0);
    chk("hold_digits", 32'(digits), 32'h05);
    chk("hold_onehot", 32'(onehot), 32'h020);
    cyc(0, 0, 0, 0, 0);
    chk("release_digits", 32'(digits), 32'h08);

    // clr during a tick cycle at 37, then start+stop together from IDLE.
    for (n = 0; n < 400 && !(m_cnt == 37 && m_pre == P - 1); n++) cyc(0, 0, 0, 0, 0);
    chk("reach_37_tick", 32'(tick), 32'd1);
    cyc(0, 0, 1, 0, 0);
    chk("clr_digits", 32'(digits), 32'h00);
    chk("clr_tc",     32'(tc), 32'd0);
    chk("clr_run",    32'(running), 32'd0);
    cyc(1, 1, 0, 0, 0);
    chk("startstop_idle_run", 32'(running), 32'd1);

    // Reset mid-run with hold high overrides every other input.
    idle_cycles(6);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 1);
    chk("rst2_digits", 32'(digits), 32'h00);
    chk("rst2_onehot", 32'(onehot), 32'h001);
    chk("rst2_run",    32'(running), 32'd0);
    chk("rst2_tc",     32'(tc), 32'd0);
    cyc(1, 0, 0, 0, 0);
    idle_cycles(4);
    chk("after_rst_digits", 32'(digits), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
